// File: rtl/ntom_sync_fifo.sv
// ---------------------------------------------------------------------------
// ntom_sync_fifo
//   Single-clock FIFO with N write lanes and M read lanes. Enabled write lanes
//   are packed in ascending lane order with gaps removed. The read side is
//   show-ahead: lane j of data_o always presents entry head+j. A burst is
//   accepted whole or rejected whole. A rejected burst raises a sticky
//   overflow or underflow flag instead of partially completing.
//
// Ports
//   clk_i         rising-edge clock
//   rst_n_i       asynchronous active-low reset (release synchronised outside)
//   data_i        N x DATA_WIDTH write data, lane 0 in the low bits
//   wr_en_i       per-lane write enable
//   rd_cnt_i      number of words to pop this cycle (0..M)
//   clr_err_i     synchronous clear of the sticky error flags
//   data_o        M x DATA_WIDTH show-ahead read data, lane 0 = head
//   valid_o       lane j valid when fill > j
//   fill_cnt_o    current number of stored entries
//   fifo_full_o   fill == DEPTH
//   fifo_afull_o  fill >= AFULL_THRESH
//   fifo_empty_o  fill == 0
//   overflow_o    sticky: a write burst did not fit
//   underflow_o   sticky: a read asked for more words than were stored
// ---------------------------------------------------------------------------
module ntom_sync_fifo #(
    parameter int N            = 4,
    parameter int M            = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 32,
    parameter int AFULL_THRESH = DEPTH - N
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [N*DATA_WIDTH-1:0]        data_i,
    input  logic [N-1:0]                   wr_en_i,
    input  logic [$clog2(M+1)-1:0]         rd_cnt_i,
    input  logic                           clr_err_i,
    output logic [M*DATA_WIDTH-1:0]        data_o,
    output logic [M-1:0]                   valid_o,
    output logic [$clog2(DEPTH+1)-1:0]     fill_cnt_o,
    output logic                           fifo_full_o,
    output logic                           fifo_afull_o,
    output logic                           fifo_empty_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);

    // Storage and registered state
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         fill_q, fill_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // Write-side packing
    logic [CW-1:0]         wr_num;
    logic [CW-1:0]         wr_acc;
    logic [CW-1:0]         rd_acc;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [N-1:0]          lane_we;
    logic [AW-1:0]         lane_addr [N];
    logic [AW-1:0]         rd_addr   [M];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        logic [AW-1:0] off;
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path leaves a value held and no latch is inferred.
        wr_num  = '0;
        off     = '0;
        lane_we = '0;
        for (int i = 0; i < N; i++) begin
            lane_addr[i] = '0;
            wr_num       = wr_num + CW'(wr_en_i[i]);
        end

        // Both acceptance tests use the fill value from before this cycle's
        // pop and push. A burst that does not fit is rejected whole.
        wr_ok  = (wr_num <= (DEPTH_C - fill_q));
        rd_ok  = (CW'(rd_cnt_i) <= fill_q);
        wr_acc = wr_ok ? wr_num : '0;
        rd_acc = rd_ok ? CW'(rd_cnt_i) : '0;

        // Each enabled lane goes to tail + (number of enabled lanes below it).
        // This removes the gaps between enabled lanes.
        for (int i = 0; i < N; i++) begin
            lane_addr[i] = (tail_q + off) & PTR_MASK;
            lane_we[i]   = wr_en_i[i] & wr_ok;
            if (wr_en_i[i]) begin
                off = off + AW'(1);
            end
        end

        fill_d = fill_q + wr_acc - rd_acc;
        tail_d = (tail_q + AW'(wr_acc)) & PTR_MASK;
        head_d = (head_q + AW'(rd_acc)) & PTR_MASK;

        // If a new error arrives in the same cycle as clr_err_i, the set wins.
        overflow_d  = (overflow_q  & ~clr_err_i) | ~wr_ok;
        underflow_d = (underflow_q & ~clr_err_i) | ~rd_ok;
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples values from before the clock edge.
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset. Emptiness is tracked by fill_q,
    // so stale contents are never presented as valid, and leaving the array
    // unreset lets it map onto plain RAM.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (lane_we[i]) begin
                mem_q[lane_addr[i]] <= data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Show-ahead read port and status. Everything here comes from registered
    // state only. A word written at an edge first appears after that edge.
    // -----------------------------------------------------------------------
    always_comb begin
        data_o  = '0;
        valid_o = '0;
        for (int j = 0; j < M; j++) begin
            rd_addr[j]                         = (head_q + AW'(j)) & PTR_MASK;
            data_o[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[j]];
            valid_o[j]                         = (fill_q > CW'(j));
        end
    end

    assign fill_cnt_o   = fill_q;
    assign fifo_full_o  = (fill_q == DEPTH_C);
    assign fifo_afull_o = (fill_q >= AFULL_C);
    assign fifo_empty_o = (fill_q == '0);
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_ntom_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_ntom_sync_fifo
//   Directed bench for ntom_sync_fifo with N=4, M=2, DATA_WIDTH=8, DEPTH=8,
//   AFULL_THRESH=4. It covers reset, packing, write latency, overflow and
//   underflow with sticky clear, simultaneous push and pop, a throttled
//   stream across pointer wrap, and reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_ntom_sync_fifo;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] data_i;
    logic [3:0]  wr_en_i;
    logic [1:0]  rd_cnt_i;
    logic        clr_err_i;
    logic [15:0] data_o;
    logic [1:0]  valid_o;
    logic [3:0]  fill_cnt_o;
    logic        fifo_full_o;
    logic        fifo_afull_o;
    logic        fifo_empty_o;
    logic        overflow_o;
    logic        underflow_o;

    int n_pass  = 0;
    int n_total = 0;

    ntom_sync_fifo #(
        .N(4), .M(2), .DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .data_i       (data_i),
        .wr_en_i      (wr_en_i),
        .rd_cnt_i     (rd_cnt_i),
        .clr_err_i    (clr_err_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .fill_cnt_o   (fill_cnt_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_afull_o (fifo_afull_o),
        .fifo_empty_o (fifo_empty_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock. Outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en_i   = 4'b0000;
        rd_cnt_i  = 2'd0;
        clr_err_i = 1'b0;
        data_i    = 32'h0;
    endtask

    initial begin
        int          sent;
        int          rx;
        int          mfill;
        int          cyc;
        logic [7:0]  expq [$];
        logic [7:0]  exp_w;

        // ---------------- reset state ----------------
        rst_n_i = 1'b0;
        idle();
        #3;
        check("rst_fill",  32'(fill_cnt_o),   32'd0);
        check("rst_empty", 32'(fifo_empty_o), 32'd1);
        check("rst_full",  32'(fifo_full_o),  32'd0);
        check("rst_afull", 32'(fifo_afull_o), 32'd0);
        check("rst_valid", 32'(valid_o),      32'd0);
        check("rst_ovf",   32'(overflow_o),   32'd0);
        check("rst_unf",   32'(underflow_o),  32'd0);
        step();
        rst_n_i = 1'b1;
        step();

        // ---------------- packing with a gap, and write latency ----------------
        wr_en_i = 4'b1010;
        data_i  = 32'h33_BB_11_AA;
        #1;
        check("lat_fill",  32'(fill_cnt_o), 32'd0);
        check("lat_valid", 32'(valid_o),    32'd0);
        step();
        idle();
        check("pack_fill",  32'(fill_cnt_o),   32'd2);
        check("pack_d0",    32'(data_o[7:0]),  32'h11);
        check("pack_d1",    32'(data_o[15:8]), 32'h33);
        check("pack_valid", 32'(valid_o),      32'd3);
        check("pack_afull", 32'(fifo_afull_o), 32'd0);

        // ---------------- overflow, full, sticky, set-wins ----------------
        wr_en_i = 4'b1111; data_i = 32'h04_03_02_01;
        step();
        check("fill6",       32'(fill_cnt_o),   32'd6);
        check("fill6_afull", 32'(fifo_afull_o), 32'd1);
        wr_en_i = 4'b1111; data_i = 32'hEE_EE_EE_EE;
        step();
        check("ovf_fill", 32'(fill_cnt_o),  32'd6);
        check("ovf_set",  32'(overflow_o),  32'd1);
        check("ovf_full", 32'(fifo_full_o), 32'd0);
        wr_en_i = 4'b0011; data_i = 32'h00_00_06_05;
        step();
        check("full_fill",   32'(fill_cnt_o),   32'd8);
        check("full_flag",   32'(fifo_full_o),  32'd1);
        check("full_afull",  32'(fifo_afull_o), 32'd1);
        check("ovf_sticky",  32'(overflow_o),   32'd1);
        wr_en_i = 4'b1111; data_i = 32'hEE_EE_EE_EE; clr_err_i = 1'b1;
        step();
        check("ovf_setwins", 32'(overflow_o), 32'd1);
        check("setwins_fill", 32'(fill_cnt_o), 32'd8);
        idle(); clr_err_i = 1'b1;
        step();
        idle();
        check("ovf_clr", 32'(overflow_o), 32'd0);

        // ---------------- drain with afull boundary ----------------
        rd_cnt_i = 2'd2;
        step();
        check("rd1_fill", 32'(fill_cnt_o),   32'd6);
        check("rd1_d0",   32'(data_o[7:0]),  32'h01);
        check("rd1_d1",   32'(data_o[15:8]), 32'h02);
        step();
        check("rd2_fill",  32'(fill_cnt_o),   32'd4);
        check("rd2_afull", 32'(fifo_afull_o), 32'd1);
        check("rd2_d0",    32'(data_o[7:0]),  32'h03);
        step();
        check("rd3_fill",  32'(fill_cnt_o),   32'd2);
        check("rd3_afull", 32'(fifo_afull_o), 32'd0);
        check("rd3_d1",    32'(data_o[15:8]), 32'h06);
        rd_cnt_i = 2'd1;
        step();
        check("rd4_fill",  32'(fill_cnt_o),  32'd1);
        check("rd4_d0",    32'(data_o[7:0]), 32'h06);
        check("rd4_valid", 32'(valid_o),     32'd1);

        // ---------------- underflow and clear ----------------
        rd_cnt_i = 2'd2;
        step();
        idle();
        check("unf_fill", 32'(fill_cnt_o),  32'd1);
        check("unf_set",  32'(underflow_o), 32'd1);
        clr_err_i = 1'b1;
        step();
        idle();
        check("unf_clr", 32'(underflow_o), 32'd0);

        // ---------------- simultaneous push and pop ----------------
        wr_en_i = 4'b0001; data_i = 32'h00_00_00_77; rd_cnt_i = 2'd1;
        step();
        idle();
        check("rw_fill", 32'(fill_cnt_o),  32'd1);
        check("rw_d0",   32'(data_o[7:0]), 32'h77);
        rd_cnt_i = 2'd1;
        step();
        idle();
        check("empty_fill",  32'(fill_cnt_o),   32'd0);
        check("empty_flag",  32'(fifo_empty_o), 32'd1);
        check("empty_valid", 32'(valid_o),      32'd0);
        check("noop_unf",    32'(underflow_o),  32'd0);

        // ---------------- throttled stream across pointer wrap ----------------
        sent = 0; rx = 0; mfill = 0; cyc = 0;
        while (rx < 40 && cyc < 400) begin
            int nw;
            int nr;
            nw = 0; nr = 0;
            if ($urandom_range(0, 3) != 0 && sent < 40 && (8 - mfill) >= 3)
                nw = (40 - sent >= 3) ? 3 : 40 - sent;
            if ($urandom_range(0, 3) != 0)
                nr = (mfill < 2) ? mfill : 2;
            wr_en_i  = 4'b0000;
            data_i   = 32'h0;
            rd_cnt_i = 2'(nr);
            for (int k = 0; k < nw; k++) begin
                wr_en_i[k]        = 1'b1;
                data_i[k*8 +: 8]  = 8'(8'h40 + sent + k);
            end
            for (int k = 0; k < nr; k++) begin
                exp_w = expq.pop_front();
                check("stream_word", 32'(data_o[k*8 +: 8]), 32'(exp_w));
            end
            for (int k = 0; k < nw; k++) expq.push_back(8'(8'h40 + sent + k));
            sent  += nw;
            rx    += nr;
            mfill += nw - nr;
            step();
            cyc++;
        end
        idle();
        check("stream_count", 32'(rx),           32'd40);
        check("stream_fill",  32'(fill_cnt_o),   32'd0);
        check("stream_ovf",   32'(overflow_o),   32'd0);
        check("stream_unf",   32'(underflow_o),  32'd0);

        // ---------------- reset mid-operation ----------------
        wr_en_i = 4'b1111; data_i = 32'h14_13_12_11;
        step();
        wr_en_i = 4'b0001; data_i = 32'h00_00_00_15;
        step();
        wr_en_i = 4'b1111; data_i = 32'hEE_EE_EE_EE;
        step();
        check("mid_fill", 32'(fill_cnt_o), 32'd5);
        check("mid_ovf",  32'(overflow_o), 32'd1);
        rst_n_i = 1'b0;
        idle();
        #2;
        check("arst_fill",  32'(fill_cnt_o),   32'd0);
        check("arst_empty", 32'(fifo_empty_o), 32'd1);
        check("arst_valid", 32'(valid_o),      32'd0);
        check("arst_ovf",   32'(overflow_o),   32'd0);
        check("arst_afull", 32'(fifo_afull_o), 32'd0);
        rst_n_i = 1'b1;
        wr_en_i = 4'b0001; data_i = 32'h00_00_00_A5;
        step();
        idle();
        check("post_rst_d0",    32'(data_o[7:0]), 32'hA5);
        check("post_rst_fill",  32'(fill_cnt_o),  32'd1);
        check("post_rst_valid", 32'(valid_o),     32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ntom_sync_fifo.md
NTOM_SYNC_FIFO -- requirements
Module: ntom_sync_fifo

Interface
REQ-001 Parameter N, default 4: number of write lanes, 1..8.
REQ-002 Parameter M, default 2: number of read lanes, 1..8.
REQ-003 Parameter DATA_WIDTH, default 8: bits per word.
REQ-004 Parameter DEPTH, default 32: entries, power of 2, >= max(N,M).
REQ-005 Parameter AFULL_THRESH, default DEPTH-N: almost-full fill level, 1..DEPTH.
REQ-006 clk_i  in  1: single clock, all logic on rising edge.
REQ-007 rst_n_i  in  1: reset; asynchronous and active-low.
REQ-008 data_i  in  N x DATA_WIDTH: write lane data, lane 0 lowest index.
REQ-009 wr_en_i  in  N: per-lane write enable.
REQ-010 rd_cnt_i  in  clog2(M+1): words to pop this cycle, 0..M.
REQ-011 data_o  out  M x DATA_WIDTH: show-ahead data, lane j = entry head+j.
REQ-012 valid_o  out  M: lane j valid when fill > j.
REQ-013 fill_cnt_o  out  clog2(DEPTH+1): current entry count.
REQ-014 fifo_full_o / fifo_afull_o / fifo_empty_o  out  1 each: fill==DEPTH / fill>=AFULL_THRESH / fill==0.
REQ-015 overflow_o / underflow_o  out  1 each: sticky error flags.
REQ-016 clr_err_i  in  1: synchronous clear of both sticky flags.

Function
REQ-017 Enabled write lanes SHALL be packed in ascending lane order with gaps removed; lane i precedes lane i+1 in FIFO order.
REQ-018 Write accepted atomically iff popcount(wr_en_i) <= DEPTH - fill (fill before this cycle's pop); otherwise no lane written and overflow_o set next cycle.
REQ-019 Read accepted iff rd_cnt_i <= fill (pre-write fill); otherwise no pop and underflow_o set next cycle.
REQ-020 Words written in cycle t SHALL NOT be visible on data_o/valid_o before cycle t+1 (one-cycle write-to-read latency).
REQ-021 Simultaneous accepted write and read: fill_next = fill + wr_accepted - rd_accepted; no combinational write-through.
REQ-022 Head and tail pointers SHALL wrap modulo DEPTH; order preserved across wrap.
REQ-023 data_o on lanes with valid_o=0 is don't-care; verification SHALL NOT check it.
REQ-024 All status outputs SHALL be registered or derived only from registered fill.
REQ-025 clr_err_i in same cycle as a new error: set wins.
REQ-026 Popcount of zero and rd_cnt_i=0 are legal no-ops and set no flags.

Reset
REQ-027 rst_n_i low SHALL asynchronously force fill=0, pointers=0, fifo_empty_o=1, fifo_full_o=0, fifo_afull_o=0, valid_o=0, overflow_o=0, underflow_o=0.
REQ-028 Storage array SHALL NOT be reset; contents after reset are unspecified.
REQ-029 Reset mid-operation SHALL discard all entries; first write after release is the new head.
REQ-030 Release is synchronised externally; block needs no internal reset synchroniser.

Verification (N=4, M=2, DATA_WIDTH=8, DEPTH=8, AFULL_THRESH=4)
REQ-031 Reset asserted -> fill_cnt_o=0, fifo_empty_o=1, valid_o=2'b00, both error flags 0.
REQ-032 wr_en_i=4'b1010, lane1=0x11, lane3=0x33 -> next cycle fill=2, data_o[0]=0x11, data_o[1]=0x33, valid_o=2'b11.
REQ-033 Fill=6, wr_en_i=4'b1111 -> fill stays 6, overflow_o=1; then wr_en_i=4'b0011 -> fill=8, fifo_full_o=1, fifo_afull_o=1.
REQ-034 Fill=1, rd_cnt_i=2 -> fill stays 1, underflow_o=1; clr_err_i pulse -> underflow_o=0.
REQ-035 40 words streamed with 3 writes and 2 reads per cycle under random throttling -> output sequence equals input sequence, no loss across pointer wrap.
REQ-036 rst_n_i dropped with fill=5 mid-stream -> outputs reach reset values without clock edge; next write 0xA5 appears at data_o[0].
